// File: rtl/mem_arb_pkg.sv
// Shared definitions for the SSRAM arbiter: FSM states, master indices, grant width.
package mem_arb_pkg;

    localparam int GNT_W = 3;

    localparam int M_VGA = 0;
    localparam int M_CPU = 1;
    localparam int M_DMA = 2;

    // Round-robin pointer encoding: which of CPU/DMA is preferred on a tie
    localparam logic RR_CPU = 1'b0;
    localparam logic RR_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: VGA fixed priority, CPU/DMA round-robin,
// with an optional mask that excludes a preempted master while others are waiting.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [GNT_W-1:0] req,
    input  logic             rr_ptr,
    input  logic [GNT_W-1:0] mask,
    output logic [GNT_W-1:0] winner
);

    logic [GNT_W-1:0] unmasked;
    logic [GNT_W-1:0] eligible;

    always_comb begin
        unmasked = req & ~mask;
        // The mask only applies when it leaves someone else to serve
        eligible = (unmasked != '0) ? unmasked : req;
        winner   = '0;
        if (eligible[M_VGA]) begin
            winner[M_VGA] = 1'b1;
        end else if (eligible[M_CPU] && eligible[M_DMA]) begin
            if (rr_ptr == RR_DMA) begin
                winner[M_DMA] = 1'b1;
            end else begin
                winner[M_CPU] = 1'b1;
            end
        end else if (eligible[M_CPU]) begin
            winner[M_CPU] = 1'b1;
        end else if (eligible[M_DMA]) begin
            winner[M_DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-master arbiter in front of the shared SSRAM controller (VGA, CPU, DMA),
// with burst limiting and a one-cycle gap between grants.
//
// state | meaning
// IDLE  | no grant; arbitrate any incoming request
// GRANT | one master owns the bus; count acks, watch for release or forced handover
// GAP   | one dead cycle with no grant; re-arbitrate honouring the preempt mask
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 4
)
(
    input  logic             sysclock,
    input  logic             rst_n,
    input  logic             vga_cyc_i,
    input  logic             cpu_cyc_i,
    input  logic             dma_cyc_i,
    input  logic             ack_i,
    output logic [GNT_W-1:0] gnt_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic [GNT_W-1:0] ack_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);

    arb_state_e       state_q, state_d;
    logic [GNT_W-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_q, rr_d;
    logic [GNT_W-1:0] pmask_q, pmask_d;

    logic [GNT_W-1:0] req;
    logic [GNT_W-1:0] pick;
    logic             granted_req;
    logic             others_req;

    assign req         = {dma_cyc_i, cpu_cyc_i, vga_cyc_i};
    assign granted_req = |(gnt_q & req);
    assign others_req  = |(req & ~gnt_q);

    arb_pick u_pick (
        .req    (req),
        .rr_ptr (rr_q),
        .mask   (pmask_q),
        .winner (pick)
    );

    always_ff @(posedge sysclock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            rr_q    <= RR_CPU;
            pmask_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            pmask_q <= pmask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        pmask_d = pmask_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                gnt_d   = '0;
                cnt_d   = '0;
                pmask_d = '0;
                state_d = ST_IDLE;
                if (req != '0) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick;
                    if (pick[M_CPU]) begin
                        rr_d = RR_DMA;
                    end else if (pick[M_DMA]) begin
                        rr_d = RR_CPU;
                    end
                end
            end
            ST_GRANT: begin
                if (ack_i && (cnt_q != BURST_LIM)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!granted_req) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (ack_i && (cnt_q >= BURST_LAST) && others_req) begin
                    // >= so a requester arriving after saturation still forces a handover
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    pmask_d = gnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign gnt_o  = gnt_q;
    assign cyc_o  = granted_req;
    assign stb_o  = granted_req;
    assign ack_o  = gnt_q & {GNT_W{ack_i}};
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: per-cycle expected output vectors queued as
// stimulus is driven, then compared against sampled outputs per scenario.
module tb_mem_arbiter;

    logic       sysclock = 1'b0;
    logic       rst_n = 1'b0;
    logic       vga_cyc_i = 1'b0;
    logic       cpu_cyc_i = 1'b0;
    logic       dma_cyc_i = 1'b0;
    logic       ack_i = 1'b0;
    logic [2:0] gnt_o;
    logic       cyc_o;
    logic       stb_o;
    logic [2:0] ack_o;
    logic       busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    // {gnt[2:0], ack[2:0], cyc, stb, busy}
    logic [8:0] sb_q[$];
    logic [8:0] obs_q[$];

    mem_arbiter #(.BURST_MAX(8), .CNT_W(4)) dut (
        .sysclock  (sysclock),
        .rst_n     (rst_n),
        .vga_cyc_i (vga_cyc_i),
        .cpu_cyc_i (cpu_cyc_i),
        .dma_cyc_i (dma_cyc_i),
        .ack_i     (ack_i),
        .gnt_o     (gnt_o),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .ack_o     (ack_o),
        .busy_o    (busy_o)
    );

    always #5 sysclock = ~sysclock;

    function automatic logic [8:0] mk(input logic [2:0] g, input logic b,
                                      input logic [2:0] rq, input logic a);
        logic c;
        c = |(g & rq);
        return {g, g & {3{a}}, c, c, b};
    endfunction

    function automatic logic [8:0] sample();
        return {gnt_o, ack_o, cyc_o, stb_o, busy_o};
    endfunction

    task automatic step(input logic v, input logic c, input logic d, input logic a,
                        input logic [2:0] eg, input logic eb);
        @(posedge sysclock);
        #1;
        vga_cyc_i = v;
        cpu_cyc_i = c;
        dma_cyc_i = d;
        ack_i     = a;
        sb_q.push_back(mk(eg, eb, {d, c, v}, a));
        @(negedge sysclock);
        obs_q.push_back(sample());
    endtask

    task automatic test_reset();
        logic [8:0] e, o;
        int idx = 0;
        step(0, 1, 0, 0, 3'b000, 0);
        step(1, 1, 1, 1, 3'b000, 0);
        step(0, 0, 0, 0, 3'b000, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 3'b000, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: gnt/ack/cyc/stb/busy got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_single_cpu();
        logic [8:0] e, o;
        int idx = 0;
        step(0, 1, 0, 0, 3'b000, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 3'b010, 1);
        step(0, 0, 0, 0, 3'b010, 1);
        step(0, 0, 0, 0, 3'b000, 1);
        step(0, 0, 0, 0, 3'b000, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single_cpu[%0d]: gnt/ack/cyc/stb/busy got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_round_robin();
        logic [8:0] e, o;
        int idx = 0;
        rst_n = 1'b0;
        step(0, 0, 0, 0, 3'b000, 0);
        rst_n = 1'b1;
        step(0, 1, 1, 0, 3'b000, 0);
        step(0, 1, 1, 1, 3'b010, 1);
        step(0, 0, 1, 0, 3'b010, 1);
        step(0, 1, 1, 0, 3'b000, 1);
        step(0, 1, 1, 1, 3'b100, 1);
        step(0, 1, 0, 0, 3'b100, 1);
        step(0, 1, 1, 0, 3'b000, 1);
        step(0, 1, 1, 0, 3'b010, 1);
        step(0, 0, 0, 0, 3'b010, 1);
        step(0, 0, 0, 0, 3'b000, 1);
        step(0, 0, 0, 0, 3'b000, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: gnt/ack/cyc/stb/busy got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_forced_handover();
        logic [8:0] e, o;
        int idx = 0;
        step(1, 1, 0, 0, 3'b000, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 3'b001, 1);
        step(1, 1, 0, 1, 3'b000, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 3'b010, 1);
        step(1, 0, 0, 0, 3'b010, 1);
        step(1, 0, 0, 0, 3'b000, 1);
        step(1, 0, 0, 1, 3'b001, 1);
        step(0, 0, 0, 0, 3'b001, 1);
        step(0, 0, 0, 0, 3'b000, 1);
        step(0, 0, 0, 0, 3'b000, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL forced_handover[%0d]: gnt/ack/cyc/stb/busy got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_unlimited_burst();
        logic [8:0] e, o;
        int idx = 0;
        step(1, 0, 0, 0, 3'b000, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 3'b001, 1);
        step(0, 0, 0, 0, 3'b001, 1);
        step(0, 0, 0, 0, 3'b000, 1);
        step(0, 0, 0, 0, 3'b000, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL unlimited_burst[%0d]: gnt/ack/cyc/stb/busy got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    // Acks in IDLE must not pre-load the burst counter: the following burst
    // must still last exactly eight acks before handover.
    task automatic test_ack_ignored();
        logic [8:0] e, o;
        int idx = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 3'b000, 0);
        step(1, 1, 0, 1, 3'b000, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 3'b001, 1);
        step(0, 1, 0, 1, 3'b000, 1);
        step(0, 0, 0, 0, 3'b010, 1);
        step(0, 0, 0, 0, 3'b000, 1);
        step(0, 0, 0, 0, 3'b000, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ack_ignored[%0d]: gnt/ack/cyc/stb/busy got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [8:0] e, o;
        int idx = 0;
        step(0, 0, 1, 0, 3'b000, 0);
        step(0, 0, 1, 1, 3'b100, 1);
        step(0, 0, 1, 1, 3'b100, 1);
        rst_n = 1'b0;
        #1;
        sb_q.push_back(mk(3'b000, 1'b0, 3'b100, 1'b1));
        obs_q.push_back(sample());
        step(0, 1, 1, 1, 3'b000, 0);
        rst_n = 1'b1;
        step(0, 1, 1, 0, 3'b010, 1);
        step(0, 0, 0, 0, 3'b010, 1);
        step(0, 0, 0, 0, 3'b000, 1);
        step(0, 0, 0, 0, 3'b000, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_burst[%0d]: gnt/ack/cyc/stb/busy got %b expected %b", idx, o, e);
            end
            idx++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_cpu();
        test_round_robin();
        test_forced_handover();
        test_unlimited_burst();
        test_ack_ignored();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
